// File: rtl/mem_arbiter_pkg.sv
// Shared CPU definitions: arbiter state/owner types, memory read type codes
// and the default transfer timeout.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_PNL = 1'b1
  } owner_t;

  // Read type codes; with DATA_READ = 1 an idle bus naturally shows 0.
  localparam logic DATA_READ   = 1'b1;
  localparam logic INSTR_FETCH = 1'b0;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// GRANT-cycle counter: counts while run is high, flags the last allowed cycle.
module bus_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds (GRANT cycles so far - 1), so this is high in the last allowed cycle.
  assign expired = run && (count_q == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / front panel) memory arbiter with round-robin priority,
// one transfer at a time, and a watchdog that aborts stalled transfers.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_read_type,
  input  logic [11:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  output logic        cpu_done,
  output logic [11:0] cpu_rdata,
  input  logic        pnl_req,
  input  logic        pnl_we,
  input  logic [11:0] pnl_addr,
  input  logic [11:0] pnl_wdata,
  output logic        pnl_done,
  output logic [11:0] pnl_rdata,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic        mem_read_type,
  output logic [11:0] mem_address,
  output logic [11:0] mem_write_data,
  input  logic [11:0] mem_read_data,
  input  logic        mem_finished,
  output logic        owner,
  output logic        bus_error
);

  arb_state_t  state_q, state_d;
  owner_t      owner_q, owner_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic        rtype_q, rtype_d;
  logic [11:0] addr_q, addr_d;
  logic [11:0] wdata_q, wdata_d;
  logic [11:0] cpu_rdata_q, cpu_rdata_d;
  logic [11:0] pnl_rdata_q, pnl_rdata_d;
  logic        cpu_done_q, cpu_done_d;
  logic        pnl_done_q, pnl_done_d;
  logic        bus_error_q, bus_error_d;
  logic        prefer_pnl_q, prefer_pnl_d;

  logic in_grant;
  logic expired;
  logic win_pnl;
  logic finish;

  assign in_grant = (state_q == GRANT);
  assign finish   = in_grant && (mem_finished || expired);
  // Panel wins when alone, or when both ask and the CPU was served last.
  assign win_pnl  = pnl_req && (!cpu_req || prefer_pnl_q);

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .run    (in_grant),
    .clear  (!in_grant),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cpu_req || pnl_req) state_d = GRANT;
      GRANT:   if (finish) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    rd_en_d      = rd_en_q;
    wr_en_d      = wr_en_q;
    rtype_d      = rtype_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    pnl_rdata_d  = pnl_rdata_q;
    cpu_done_d   = 1'b0;
    pnl_done_d   = 1'b0;
    bus_error_d  = bus_error_q;
    prefer_pnl_d = prefer_pnl_q;

    if ((state_q == IDLE) && (cpu_req || pnl_req)) begin
      owner_d      = win_pnl ? OWNER_PNL : OWNER_CPU;
      prefer_pnl_d = !win_pnl;
      if (win_pnl) begin
        rd_en_d = !pnl_we;
        wr_en_d = pnl_we;
        rtype_d = pnl_we ? 1'b0 : DATA_READ;
        addr_d  = pnl_addr;
        wdata_d = pnl_wdata;
      end else begin
        rd_en_d = !cpu_we;
        wr_en_d = cpu_we;
        rtype_d = cpu_we ? 1'b0 : cpu_read_type;
        addr_d  = cpu_addr;
        wdata_d = cpu_wdata;
      end
    end

    if (finish) begin
      rd_en_d = 1'b0;
      wr_en_d = 1'b0;
      rtype_d = 1'b0;
      if (owner_q == OWNER_PNL) pnl_done_d = 1'b1;
      else                      cpu_done_d = 1'b1;
      // A real completion beats a coinciding timeout.
      if (mem_finished) begin
        if (rd_en_q) begin
          if (owner_q == OWNER_PNL) pnl_rdata_d = mem_read_data;
          else                      cpu_rdata_d = mem_read_data;
        end
      end else begin
        bus_error_d = 1'b1;
        if (owner_q == OWNER_PNL) pnl_rdata_d = '0;
        else                      cpu_rdata_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= OWNER_CPU;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      rtype_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      pnl_rdata_q  <= '0;
      cpu_done_q   <= 1'b0;
      pnl_done_q   <= 1'b0;
      bus_error_q  <= 1'b0;
      prefer_pnl_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      rtype_q      <= rtype_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      pnl_rdata_q  <= pnl_rdata_d;
      cpu_done_q   <= cpu_done_d;
      pnl_done_q   <= pnl_done_d;
      bus_error_q  <= bus_error_d;
      prefer_pnl_q <= prefer_pnl_d;
    end
  end

  assign mem_read_enable  = rd_en_q;
  assign mem_write_enable = wr_en_q;
  assign mem_read_type    = rtype_q;
  assign mem_address      = addr_q;
  assign mem_write_data   = wdata_q;
  assign cpu_rdata        = cpu_rdata_q;
  assign pnl_rdata        = pnl_rdata_q;
  assign cpu_done         = cpu_done_q;
  assign pnl_done         = pnl_done_q;
  assign owner            = owner_q;
  assign bus_error        = bus_error_q;

endmodule
